// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared definitions for the CPU front end: data width, the NOP
//            encoding used as the fetch reset word, the fetch FSM state type
//            and a small alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int XLEN = 32;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,   // ready to issue a read for the current PC
    WAIT  = 2'd1,   // one read outstanding, response expected
    DRAIN = 2'd2    // outstanding read was flushed, swallow its response
  } fetch_state_t;

  // A 32-bit instruction fetch must be word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ============================================================================
// Module   : fetch_out_reg
// Purpose  : Valid/ready output register between fetch and decode. Holds one
//            instruction word with its PC and fault flag.
// Ports    : clk, reset (async, active-low)
//            load, load_instr, load_pc, load_fault : capture a new entry
//            flush : drop the held entry
//            ready : consumer accepts the held entry
//            valid, instr, pc, fault : registered entry toward decode
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_out_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INSTR = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            load_fault,
  input  logic            flush,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            fault
);

  // Payload only changes on load, so it holds its last value while invalid.
  // A load never coincides with flush: the fetch FSM gates it with !flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= RESET_INSTR;
      pc    <= '0;
      fault <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      fault <= load_fault;
    end else if (flush || ready) begin
      valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage downstream of the program counter. Issues one
//            instruction-memory read per PC value (single outstanding read),
//            drives the PC enable, and presents the returned word with its PC
//            to decode through a valid/ready register. Redirect flushes
//            discard in-flight data.
// Ports    : clk, reset (async, active-low)
//            pc, pc_en, flush                      : PC stage interface
//            mem_req_valid/addr/ready              : memory request
//            mem_resp_valid/data                   : memory response
//            out_valid/ready/instr/pc/fault        : toward decode
// Options  : IFETCH_ALIGN_CHECK_EN - when defined, a misaligned PC is not
//            fetched; a fault entry (out_fault=1, out_instr=RESET_INSTR) is
//            presented instead and fetch stalls until the next flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_INSTR = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_en,
  input  logic            flush,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_fault
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] req_pc;
  logic            out_free;
  logic            req_fire;
  logic            resp_load;
  logic            fault_fire;
  logic            misaligned;
  logic            fault_block;

  // The output register can take a new entry next cycle.
  assign out_free = !out_valid || out_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_hold;

  assign misaligned  = is_misaligned(pc);
  assign fault_block = fault_hold;

  // After reporting a misaligned PC, stop re-reporting it; only a redirect
  // can supply a new PC worth testing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_hold <= 1'b0;
    end else if (flush) begin
      fault_hold <= 1'b0;
    end else if (fault_fire) begin
      fault_hold <= 1'b1;
    end
  end
`else
  assign misaligned  = 1'b0;
  assign fault_block = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= REQ;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    mem_req_valid = 1'b0;
    resp_load     = 1'b0;
    fault_fire    = 1'b0;
    case (state)
      REQ: begin
        // A flush means the PC stage is loading a target this edge, so the
        // current pc is stale and must not be requested.
        mem_req_valid = out_free && !flush && !misaligned;
        fault_fire    = out_free && !flush && misaligned && !fault_block;
        if (mem_req_valid && mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          // Response in this same cycle is dropped and nothing remains in
          // flight; otherwise the late response must be swallowed.
          state_next = mem_resp_valid ? REQ : DRAIN;
        end else if (mem_resp_valid) begin
          resp_load  = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (mem_resp_valid) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  assign req_fire     = mem_req_valid && mem_req_ready;
  assign pc_en        = req_fire || flush;
  assign mem_req_addr = pc;

  // PC of the outstanding read, paired with its data on return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc <= '0;
    end else if (req_fire) begin
      req_pc <= pc;
    end
  end

  // --------------------------------------------------------------------------
  // Output register toward decode
  // --------------------------------------------------------------------------
  fetch_out_reg #(
    .RESET_INSTR (RESET_INSTR)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (resp_load || fault_fire),
    .load_instr (fault_fire ? RESET_INSTR : mem_resp_data),
    .load_pc    (fault_fire ? pc : req_pc),
    .load_fault (fault_fire),
    .flush      (flush),
    .ready      (out_ready),
    .valid      (out_valid),
    .instr      (out_instr),
    .pc         (out_pc),
    .fault      (out_fault)
  );

  // A response with nothing outstanding breaks the memory protocol.
  a_no_resp_in_req : assert property (
    @(posedge clk) disable iff (!reset) !(state == REQ && mem_resp_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. Models the upstream PC stage
//            and a simple instruction memory; expected decode-side entries are
//            queued by the stimulus thread and compared by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_en;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  logic [31:0] target;
  logic [1:0]  pend_cnt;
  logic [31:0] pend_data;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .pc_en          (pc_en),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image
  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00a00113;
      32'h8:   return 32'h002081b3;
      32'hC:   return 32'h40208233;
      32'h10:  return 32'h0041a2b3;
      default: return 32'hA0000000 | a;
    endcase
  endfunction

  // Address 0x14 answers after two cycles, everything else after one.
  function automatic logic [1:0] lat_of(input logic [31:0] a);
    return (a == 32'h14) ? 2'd2 : 2'd1;
  endfunction

  // Upstream PC stage: advance by 4, or load the redirect target.
  always @(posedge clk or negedge reset) begin
    if (!reset)     pc <= 32'h0;
    else if (pc_en) pc <= flush ? target : pc + 32'd4;
  end

  // Instruction memory
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_cnt  <= 2'd0;
      pend_data <= 32'h0;
    end else if (mem_req_valid && mem_req_ready) begin
      pend_cnt  <= lat_of(mem_req_addr);
      pend_data <= memf(mem_req_addr);
    end else if (pend_cnt != 2'd0) begin
      pend_cnt <= pend_cnt - 2'd1;
    end
  end
  assign mem_resp_valid = (pend_cnt == 2'd1);
  assign mem_resp_data  = pend_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic f);
    exp_t e;
    e.pc = p; e.instr = i; e.fault = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every decode handshake consumes one expected entry.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output_pc", out_pc, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_fault", {31'd0, out_fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit hit = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      sample();
      if (mem_req_valid && mem_req_addr == a) begin
        hit = 1'b1;
        break;
      end
    end
    check("wait_req_seen", {31'd0, hit}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset         = 1'b0;
    flush         = 1'b0;
    target        = 32'h0;
    out_ready     = 1'b0;
    mem_req_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    sample();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h00000013);
    check("rst_out_pc",    out_pc,    32'h0);
    check("rst_out_fault", {31'd0, out_fault}, 32'd0);

    // First fetch: request in cycle 1, data in cycle 3
    tick(); reset = 1'b1;
    sample();
    check("c1_pc_en",    {31'd0, pc_en},         32'd1);
    check("c1_req_valid",{31'd0, mem_req_valid}, 32'd1);
    check("c1_req_addr", mem_req_addr, 32'h0);
    push(32'h0, 32'h00500093, 1'b0);
    tick(); sample();
    check("c2_pc_en",     {31'd0, pc_en},     32'd0);
    check("c2_out_valid", {31'd0, out_valid}, 32'd0);
    tick(); sample();
    check("c3_out_valid", {31'd0, out_valid}, 32'd1);
    check("c3_out_pc",    out_pc,    32'h0);
    check("c3_out_instr", out_instr, 32'h00500093);

    // Decode back-pressure: no fetch while the output is held
    for (int i = 0; i < 5; i++) begin
      tick(); sample();
      check("bp_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("bp_pc_en",     {31'd0, pc_en},         32'd0);
      check("bp_out_instr", out_instr, 32'h00500093);
    end
    tick(); out_ready = 1'b1;
    push(32'h4, 32'h00a00113, 1'b0);
    push(32'h8, 32'h002081b3, 1'b0);
    push(32'hC, 32'h40208233, 1'b0);
    sample();
    check("resume_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("resume_pc_en",     {31'd0, pc_en},         32'd1);
    check("resume_req_addr",  mem_req_addr, 32'h4);

    // Memory stall at 0x10
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); sample();
      if (pc == 32'h10) begin
        seen = 1'b1;
        break;
      end
    end
    check("pc_reached_0x10", {31'd0, seen}, 32'd1);
    mem_req_ready = 1'b0;
    push(32'h10, 32'h0041a2b3, 1'b0);
    wait_req(32'h10);
    check("stall_pc_en_0", {31'd0, pc_en}, 32'd0);
    for (int i = 1; i < 3; i++) begin
      tick(); sample();
      check("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("stall_req_addr",  mem_req_addr, 32'h10);
      check("stall_pc_en",     {31'd0, pc_en}, 32'd0);
    end
    tick(); mem_req_ready = 1'b1;
    sample();
    check("stall_accept_pc_en", {31'd0, pc_en}, 32'd1);
    check("stall_accept_addr",  mem_req_addr, 32'h10);

    // Flush while waiting; stale response arrives two cycles after request
    wait_req(32'h14);
    tick(); flush = 1'b1; target = 32'h200;
    sample();
    check("fw_pc_en",     {31'd0, pc_en},         32'd1);
    check("fw_req_valid", {31'd0, mem_req_valid}, 32'd0);
    tick(); flush = 1'b0;
    sample();
    check("fw_drain_out_valid", {31'd0, out_valid}, 32'd0);
    tick(); sample();
    check("fw_after_out_valid", {31'd0, out_valid}, 32'd0);
    check("fw_req_valid_tgt",   {31'd0, mem_req_valid}, 32'd1);
    check("fw_req_addr_tgt",    mem_req_addr, 32'h200);

    // Flush coinciding with the response: no drain, immediate refetch
    tick(); flush = 1'b1; target = 32'h300;
    sample();
    check("fr_resp_seen", {31'd0, mem_resp_valid}, 32'd1);
    check("fr_pc_en",     {31'd0, pc_en},          32'd1);
    tick(); flush = 1'b0;
    sample();
    check("fr_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("fr_req_addr",  mem_req_addr, 32'h300);
    check("fr_out_valid", {31'd0, out_valid}, 32'd0);
    push(32'h300, 32'hA0000300, 1'b0);
    tick(); sample();
    tick(); sample();
    tick(); out_ready = 1'b0;
    sample();
    tick(); sample();

    // Redirect to a misaligned target
    tick(); flush = 1'b1; target = 32'h102;
    sample();
    check("mis_flush_pc_en",   {31'd0, pc_en},         32'd1);
    check("mis_flush_req",     {31'd0, mem_req_valid}, 32'd0);
    tick(); flush = 1'b0;
    sample();
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("mis_pc_en",     {31'd0, pc_en},         32'd0);
    tick(); sample();
    check("mis_out_valid", {31'd0, out_valid}, 32'd1);
    check("mis_out_fault", {31'd0, out_fault}, 32'd1);
    check("mis_out_pc",    out_pc,    32'h102);
    check("mis_out_instr", out_instr, 32'h00000013);
    tick(); sample();
    check("mis_hold_req_valid", {31'd0, mem_req_valid}, 32'd0);
`else
    check("mis_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check("mis_req_addr",  mem_req_addr, 32'h102);
    check("mis_pc_en",     {31'd0, pc_en}, 32'd1);
    tick(); sample();
    check("mis_out_fault", {31'd0, out_fault}, 32'd0);
    tick(); sample();
    check("mis_out_valid", {31'd0, out_valid}, 32'd1);
    check("mis_out_pc",    out_pc,    32'h102);
    check("mis_out_instr", out_instr, 32'hA0000102);
    check("mis_out_fault2", {31'd0, out_fault}, 32'd0);
`endif

    repeat (3) begin
      tick(); sample();
    end
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
